// File: rtl/spi_readout_pkg.sv
// Shared definitions for the SPI frame-buffer readout controller.
//   CMD_READ / CMD_STATUS : command byte values
//   state_t               : controller FSM states
//   wrap_inc()            : address increment with wrap at the memory depth
package spi_readout_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_STATUS = 3'd4,
    ST_IGNORE = 3'd5
  } state_t;

  // Next address after addr in a memory of depth words; wraps to 0.
  function automatic logic [31:0] wrap_inc(input logic [31:0] addr,
                                           input int unsigned depth);
    if (addr >= depth - 1) return '0;
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchroniser for the SPI pins into the system clock domain.
//   clk, resetn : system clock, asynchronous active-low reset
//   sck/cs/copi : raw SPI pins
//   cs_s/copi_s : synchronised chip select and data
//   sck_rise    : one-cycle pulse on a synchronised sck rising edge
//   sck_fall    : one-cycle pulse on a synchronised sck falling edge
//   cs_rise     : one-cycle pulse on a synchronised cs rising edge
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic sck,
  input  logic cs,
  input  logic copi,
  output logic cs_s,
  output logic copi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] copi_q;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sck_q  <= '0;
      cs_q   <= '0;
      copi_q <= '0;
      sck_d  <= 1'b0;
      cs_d   <= 1'b0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
      copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
      sck_d  <= sck_q[SYNC_STAGES-1];
      cs_d   <= cs_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign copi_s   = copi_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;

endmodule

// File: rtl/spi_readout_controller.sv
// Oversampled SPI target (mode 0) giving the nRF read access to the camera
// frame buffer. Commands: READ (0x03) + address, then streamed words with
// auto-increment and wrap; STATUS (0x05) returns {7'b0, frame_ready}.
//   clk, resetn  : system clock, asynchronous active-low reset
//   sck, cs, copi: SPI inputs (cs active high)
//   cipo         : SPI output
//   mem_addr     : frame-buffer read address
//   mem_rd_en    : read strobe, mem_data valid on the following clk
//   mem_data     : frame-buffer read data
//   frame_ready  : frame-complete level from the capture block
//   frame_ack    : pulse when a STATUS byte has reported frame_ready=1
module spi_readout_controller
  import spi_readout_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned MEM_DEPTH   = 1536,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  copi,
  output logic                  cipo,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  frame_ready,
  output logic                  frame_ack
);

  localparam int unsigned IW = $clog2(ADDR_WIDTH + 1);
  localparam int unsigned OW = $clog2(DATA_WIDTH + 1);

  logic cs_s, copi_s, sck_rise, sck_fall, cs_rise;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .sck     (sck),
    .cs      (cs),
    .copi    (copi),
    .cs_s    (cs_s),
    .copi_s  (copi_s),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .cs_rise (cs_rise)
  );

  state_t                  state;
  logic [IW-1:0]           in_cnt;
  logic [OW-1:0]           out_cnt;
  logic [ADDR_WIDTH-1:0]   shift_in;
  logic [DATA_WIDTH-1:0]   shift_out;
  logic [DATA_WIDTH-1:0]   prefetch;
  logic                    rd_pending;
  logic                    first_load;
  logic                    stat_bit;
  logic                    stat_done;

  logic [ADDR_WIDTH-1:0]   shift_in_nxt;
  logic [ADDR_WIDTH-1:0]   addr_mod;
  logic [ADDR_WIDTH-1:0]   addr_inc;
  logic [DATA_WIDTH-1:0]   stat_word;
  logic [DATA_WIDTH-1:0]   stat_entry;
  logic [DATA_WIDTH-1:0]   reload_word;
  logic [OW-1:0]           word_len;
  logic                    in_status;

  assign shift_in_nxt = {shift_in[ADDR_WIDTH-2:0], copi_s};
  assign addr_mod     = ADDR_WIDTH'(32'(shift_in_nxt) % MEM_DEPTH);
  assign addr_inc     = ADDR_WIDTH'(wrap_inc(32'(mem_addr), MEM_DEPTH));
  // Status byte sits in the top 8 bits of the out-shift register.
  assign stat_word    = DATA_WIDTH'({7'b0, stat_bit}) << (DATA_WIDTH - 8);
  assign stat_entry   = DATA_WIDTH'({7'b0, frame_ready}) << (DATA_WIDTH - 8);
  assign in_status    = (state == ST_STATUS);
  assign word_len     = in_status ? OW'(8) : OW'(DATA_WIDTH);
  assign reload_word  = in_status ? stat_word : prefetch;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      prefetch   <= '0;
      rd_pending <= 1'b0;
      first_load <= 1'b0;
      stat_bit   <= 1'b0;
      stat_done  <= 1'b0;
      cipo       <= 1'b0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      frame_ack  <= 1'b0;
    end else begin
      mem_rd_en  <= 1'b0;
      frame_ack  <= 1'b0;
      rd_pending <= mem_rd_en;

      if (!cs_s) begin
        // Abort has priority over any same-cycle sck edge.
        state      <= ST_IDLE;
        cipo       <= 1'b0;
        in_cnt     <= '0;
        out_cnt    <= '0;
        shift_in   <= '0;
        shift_out  <= '0;
        rd_pending <= 1'b0;
        first_load <= 1'b0;
        stat_done  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (cs_rise) begin
              state  <= ST_CMD;
              in_cnt <= '0;
              cipo   <= 1'b0;
            end
          end

          ST_CMD: begin
            if (sck_rise) begin
              shift_in <= shift_in_nxt;
              if (in_cnt == IW'(7)) begin
                in_cnt  <= '0;
                out_cnt <= '0;
                if (shift_in_nxt[7:0] == CMD_READ) begin
                  state <= ST_ADDR;
                end else if (shift_in_nxt[7:0] == CMD_STATUS) begin
                  state     <= ST_STATUS;
                  stat_bit  <= frame_ready;
                  shift_out <= stat_entry;
                  stat_done <= 1'b0;
                end else begin
                  state <= ST_IGNORE;
                end
              end else begin
                in_cnt <= in_cnt + 1'b1;
              end
            end
          end

          ST_ADDR: begin
            if (sck_rise) begin
              shift_in <= shift_in_nxt;
              if (in_cnt == IW'(ADDR_WIDTH - 1)) begin
                in_cnt     <= '0;
                out_cnt    <= '0;
                mem_addr   <= addr_mod;
                mem_rd_en  <= 1'b1;
                first_load <= 1'b1;
                state      <= ST_DATA;
              end else begin
                in_cnt <= in_cnt + 1'b1;
              end
            end
          end

          ST_DATA: begin
            if (rd_pending) begin
              if (first_load) begin
                shift_out  <= mem_data;
                first_load <= 1'b0;
                mem_addr   <= addr_inc;
                mem_rd_en  <= 1'b1;
              end else begin
                prefetch <= mem_data;
              end
            end
          end

          ST_STATUS: begin
            if (sck_rise && !stat_done) begin
              if (in_cnt == IW'(7)) begin
                in_cnt    <= '0;
                stat_done <= 1'b1;
                frame_ack <= stat_bit;
              end else begin
                in_cnt <= in_cnt + 1'b1;
              end
            end
          end

          ST_IGNORE: cipo <= 1'b0;

          default: state <= ST_IDLE;
        endcase

        // Output shifting shared by DATA and STATUS. Once every bit of the
        // current word has been presented, the fall that would present the
        // next bit instead reloads and presents the next word's MSB, so the
        // stream has no gap bits.
        if (sck_fall && (state == ST_DATA || state == ST_STATUS)) begin
          if (out_cnt == word_len) begin
            cipo      <= reload_word[DATA_WIDTH-1];
            shift_out <= reload_word << 1;
            out_cnt   <= OW'(1);
            if (state == ST_DATA) begin
              mem_addr  <= addr_inc;
              mem_rd_en <= 1'b1;
            end
          end else begin
            cipo      <= shift_out[DATA_WIDTH-1];
            shift_out <= shift_out << 1;
            out_cnt   <= out_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_readout_controller.sv
// Testbench for spi_readout_controller: SPI master tasks, a frame-buffer
// memory model, and expected values derived from the memory contents.
module tb_spi_readout_controller;
  import spi_readout_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1536;
  localparam int          HALF  = 50;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sck = 1'b0;
  logic          cs = 1'b0;
  logic          copi = 1'b0;
  logic          frame_ready = 1'b0;
  logic          cipo;
  logic          mem_rd_en;
  logic          frame_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int ack_cnt = 0;
  int cipo_hi = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  spi_readout_controller #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sck        (sck),
    .cs         (cs),
    .copi       (copi),
    .cipo       (cipo),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_data   (mem_data),
    .frame_ready(frame_ready),
    .frame_ack  (frame_ack)
  );

  always @(posedge clk)
    if (mem_rd_en) mem_data <= (mem_addr < DEPTH) ? mem[mem_addr] : 8'hEE;

  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (frame_ack) ack_cnt++;
    if (mon_en && cipo) cipo_hi++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 byte: copi set while sck low, cipo sampled on the rising edge.
  // With last set, cs drops together with the final falling edge.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit last,
                          input int flip, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      copi = tx[7-i];
      if (i == flip) frame_ready = ~frame_ready;
      #HALF;
      sck = 1'b1;
      rx = {rx[6:0], cipo};
      #HALF;
      sck = 1'b0;
      if (last && i == nbits - 1) cs = 1'b0;
    end
  endtask

  task automatic start_txn();
    cs = 1'b1;
    #40;
  endtask

  task automatic read_txn(input logic [15:0] start, input int n, input string tag);
    logic [7:0] rx;
    int base;
    int r0;
    base = int'(start) % DEPTH;
    r0 = rd_cnt;
    start_txn();
    spi_byte(CMD_READ, 8, 1'b0, -1, rx);
    spi_byte(start[15:8], 8, 1'b0, -1, rx);
    spi_byte(start[7:0], 8, 1'b0, -1, rx);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'($urandom), 8, k == n - 1, -1, rx);
      check($sformatf("%s_byte%0d", tag, k), 32'(rx), 32'(mem[(base + k) % DEPTH]));
    end
    #200;
    check({tag, "_addr_end"}, 32'(mem_addr), 32'((base + n) % DEPTH));
    check({tag, "_reads"}, 32'(rd_cnt - r0), 32'(n + 1));
  endtask

  task automatic status_txn(input logic fr, input int n, input int flip, input string tag);
    logic [7:0] rx;
    int a0;
    frame_ready = fr;
    a0 = ack_cnt;
    start_txn();
    spi_byte(CMD_STATUS, 8, 1'b0, -1, rx);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'($urandom), 8, k == n - 1, (k == 0) ? flip : -1, rx);
      check($sformatf("%s_byte%0d", tag, k), 32'(rx), {31'b0, fr});
    end
    #200;
    check({tag, "_acks"}, 32'(ack_cnt - a0), {31'b0, fr});
    frame_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] rx;
    int r0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    @(negedge clk);

    // Reset held while the bus is active.
    resetn = 1'b0;
    cs = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sck = ~sck;
      #30;
      if (i % 2 == 1)
        check($sformatf("reset_outputs%0d", i), {29'b0, cipo, mem_rd_en, frame_ack}, 32'd0);
    end
    check("reset_addr", 32'(mem_addr), 32'd0);
    cs = 1'b0;
    sck = 1'b0;
    #20;
    resetn = 1'b1;
    #50;
    check("reset_state", 32'(dut.state), 32'(ST_IDLE));

    read_txn(16'h0010, 4, "read_0010");
    #100;
    read_txn(16'h05FE, 3, "read_wrap");
    #100;
    read_txn(16'h0700, 2, "read_mod");
    #100;

    status_txn(1'b1, 2, -1, "status1");
    #100;
    status_txn(1'b0, 2, -1, "status0");
    #100;
    status_txn(1'b1, 1, 3, "status_flip");
    #100;

    // Abort three bits into the first data word.
    start_txn();
    spi_byte(CMD_READ, 8, 1'b0, -1, rx);
    spi_byte(8'h00, 8, 1'b0, -1, rx);
    spi_byte(8'h30, 8, 1'b0, -1, rx);
    spi_byte(8'h00, 3, 1'b0, -1, rx);
    cs = 1'b0;
    r0 = rd_cnt;
    #300;
    check("abort_no_reads", 32'(rd_cnt - r0), 32'd0);
    read_txn(16'h0020, 2, "post_abort");
    #100;

    // Unknown command followed by 16 clocks.
    mon_en = 1'b1;
    r0 = rd_cnt;
    start_txn();
    spi_byte(8'hAA, 8, 1'b0, -1, rx);
    spi_byte(8'($urandom), 8, 1'b0, -1, rx);
    check("ignore_byte0", 32'(rx), 32'd0);
    spi_byte(8'($urandom), 8, 1'b1, -1, rx);
    check("ignore_byte1", 32'(rx), 32'd0);
    #200;
    mon_en = 1'b0;
    check("ignore_cipo_high", 32'(cipo_hi), 32'd0);
    check("ignore_reads", 32'(rd_cnt - r0), 32'd0);
    #100;

    // Randomised reads over random memory contents.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      read_txn(16'($urandom_range(0, 65535)), int'($urandom_range(1, 5)),
               $sformatf("rand_read%0d", r));
      #100;
    end
    for (int r = 0; r < 3; r++) begin
      status_txn(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)), -1,
                 $sformatf("rand_status%0d", r));
      #100;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
